// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: owns the mm:ss BCD count and binary total seconds,
// and runs the PAUSE/RUN/ADJUST state machine driven by debounced buttons and
// clkdiv tick pulses.
// Optional build macro: STOPWATCH_SATURATE_EN (count stops at MIN_MAX:59 instead of wrapping).
module stopwatch_ctrl #(
   parameter int unsigned MIN_MAX = 99,
   parameter int unsigned TOTAL_W = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_1hz,
   input  logic               tick_adj,
   input  logic               btn_reset,
   input  logic               btn_set_pause,
   input  logic               adj,
   input  logic [1:0]         sel,
   input  logic [3:0]         num,
   output logic [15:0]        digits,
   output logic [TOTAL_W-1:0] total_seconds,
   output logic               running,
   output logic [3:0]         blink_mask,
   output logic               wrap
);

   typedef enum logic [1:0] {StPause, StRun, StAdjust} state_e;

   localparam logic [3:0] MaxTens = 4'(MIN_MAX / 10);
   localparam logic [3:0] MaxOnes = 4'(MIN_MAX % 10);
   localparam logic [6:0] MaxMin  = 7'(MIN_MAX);

   state_e             state_q, state_d;
   logic [3:0]         sec_o_q, sec_o_d;
   logic [3:0]         sec_t_q, sec_t_d;
   logic [3:0]         min_o_q, min_o_d;
   logic [3:0]         min_t_q, min_t_d;
   logic [TOTAL_W-1:0] tot_q, tot_d;
   logic               recalc_q, recalc_d;
   logic               running_q, running_d;
   logic [3:0]         mask_q, mask_d;
   logic               wrap_q, wrap_d;
   logic               phase_q, phase_d;
   // Two-stage button history: stage 1 samples the level, stage 2 delays it for edge detect
   logic               rst_s1_q, rst_s2_q;
   logic               sp_s1_q, sp_s2_q;

   logic               rst_ev;
   logic               sp_ev;
   logic               min_at_max;
   logic               sat_hit;
   logic               load_ok;
   logic [6:0]         min_new;
   logic [TOTAL_W-1:0] tot_calc;

   assign rst_ev     = rst_s1_q & ~rst_s2_q;
   assign sp_ev      = sp_s1_q & ~sp_s2_q;
   assign min_at_max = (min_t_q == MaxTens) && (min_o_q == MaxOnes);

   // Binary seconds recomputed from the BCD digits after an adjust load
   assign tot_calc = TOTAL_W'(min_t_q) * TOTAL_W'(600) + TOTAL_W'(min_o_q) * TOTAL_W'(60) +
                     TOTAL_W'(sec_t_q) * TOTAL_W'(10) + TOTAL_W'(sec_o_q);

   // Validate an adjust load against digit range and the minute ceiling
   always_comb begin
      load_ok = 1'b0;
      min_new = 7'd0;
      unique case (sel)
         2'd0: load_ok = (num <= 4'd9);
         2'd1: load_ok = (num <= 4'd5);
         2'd2: begin
            min_new = 7'(min_t_q) * 7'd10 + 7'(num);
            load_ok = (num <= 4'd9) && (min_new <= MaxMin);
         end
         default: begin
            min_new = 7'(num) * 7'd10 + 7'(min_o_q);
            load_ok = (num <= 4'd9) && (min_new <= MaxMin);
         end
      endcase
   end

   // Count datapath: reset clear, run increment, adjust load, deferred total recompute
   always_comb begin
      sec_o_d  = sec_o_q;
      sec_t_d  = sec_t_q;
      min_o_d  = min_o_q;
      min_t_d  = min_t_q;
      tot_d    = tot_q;
      recalc_d = 1'b0;
      wrap_d   = 1'b0;
      sat_hit  = 1'b0;
      if (rst_ev) begin
         sec_o_d = 4'd0;
         sec_t_d = 4'd0;
         min_o_d = 4'd0;
         min_t_d = 4'd0;
         tot_d   = '0;
      end else if (state_q == StRun && tick_1hz) begin
`ifdef STOPWATCH_SATURATE_EN
         if (min_at_max && sec_t_q == 4'd5 && sec_o_q == 4'd9) begin
            // Full: hold the count, flag it, and let the FSM drop to PAUSE
            sat_hit = 1'b1;
            wrap_d  = 1'b1;
         end else begin
`else
         begin
`endif
            if (sec_o_q != 4'd9) begin
               sec_o_d = sec_o_q + 4'd1;
            end else begin
               sec_o_d = 4'd0;
               if (sec_t_q != 4'd5) begin
                  sec_t_d = sec_t_q + 4'd1;
               end else begin
                  sec_t_d = 4'd0;
                  if (min_at_max) begin
                     min_o_d = 4'd0;
                     min_t_d = 4'd0;
                     wrap_d  = 1'b1;
                  end else if (min_o_q != 4'd9) begin
                     min_o_d = min_o_q + 4'd1;
                  end else begin
                     min_o_d = 4'd0;
                     min_t_d = min_t_q + 4'd1;
                  end
               end
            end
            tot_d = wrap_d ? '0 : tot_q + TOTAL_W'(1);
         end
      end else if (state_q == StAdjust && sp_ev && load_ok) begin
         unique case (sel)
            2'd0:    sec_o_d = num;
            2'd1:    sec_t_d = num;
            2'd2:    min_o_d = num;
            default: min_t_d = num;
         endcase
         recalc_d = 1'b1;
      end else if (recalc_q) begin
         tot_d = tot_calc;
      end
   end

   // Next state, blink phase and registered status outputs
   always_comb begin
      state_d = state_q;
      if (adj) begin
         state_d = StAdjust;
      end else if (state_q == StAdjust) begin
         state_d = StPause;
      end else if (sat_hit) begin
         state_d = StPause;
      end else if (rst_ev) begin
         // Reset press drops RUN to PAUSE and swallows a coincident set/pause press
         state_d = StPause;
      end else if (sp_ev) begin
         state_d = (state_q == StPause) ? StRun : StPause;
      end

      phase_d = 1'b0;
      if (state_d == StAdjust) begin
         phase_d = (state_q == StAdjust && tick_adj) ? ~phase_q : phase_q;
      end
      mask_d    = (state_d == StAdjust && phase_d) ? (4'b0001 << sel) : 4'b0000;
      running_d = (state_d == StRun);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StPause;
         sec_o_q   <= 4'd0;
         sec_t_q   <= 4'd0;
         min_o_q   <= 4'd0;
         min_t_q   <= 4'd0;
         tot_q     <= '0;
         recalc_q  <= 1'b0;
         running_q <= 1'b0;
         mask_q    <= 4'd0;
         wrap_q    <= 1'b0;
         phase_q   <= 1'b0;
         rst_s1_q  <= 1'b0;
         rst_s2_q  <= 1'b0;
         sp_s1_q   <= 1'b0;
         sp_s2_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sec_o_q   <= sec_o_d;
         sec_t_q   <= sec_t_d;
         min_o_q   <= min_o_d;
         min_t_q   <= min_t_d;
         tot_q     <= tot_d;
         recalc_q  <= recalc_d;
         running_q <= running_d;
         mask_q    <= mask_d;
         wrap_q    <= wrap_d;
         phase_q   <= phase_d;
         rst_s1_q  <= btn_reset;
         rst_s2_q  <= rst_s1_q;
         sp_s1_q   <= btn_set_pause;
         sp_s2_q   <= sp_s1_q;
      end
   end

   assign digits        = {min_t_q, min_o_q, sec_t_q, sec_o_q};
   assign total_seconds = tot_q;
   assign running       = running_q;
   assign blink_mask    = mask_q;
   assign wrap          = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: adjust-load vector table plus hand-written
// sequences for run, reset priority, button hold, blink and wrap behaviour.
module tb_stopwatch_ctrl;

   localparam int unsigned TOTAL_W = 13;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               tick_1hz = 1'b0;
   logic               tick_adj = 1'b0;
   logic               btn_reset = 1'b0;
   logic               btn_set_pause = 1'b0;
   logic               adj = 1'b0;
   logic [1:0]         sel = 2'd0;
   logic [3:0]         num = 4'd0;
   logic [15:0]        digits;
   logic [TOTAL_W-1:0] total_seconds;
   logic               running;
   logic [3:0]         blink_mask;
   logic               wrap;

   stopwatch_ctrl #(.MIN_MAX(99), .TOTAL_W(TOTAL_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .tick_1hz      (tick_1hz),
      .tick_adj      (tick_adj),
      .btn_reset     (btn_reset),
      .btn_set_pause (btn_set_pause),
      .adj           (adj),
      .sel           (sel),
      .num           (num),
      .digits        (digits),
      .total_seconds (total_seconds),
      .running       (running),
      .blink_mask    (blink_mask),
      .wrap          (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [15:0] dig;
      int          tot;
      logic        run;
      logic [3:0]  mask;
      logic        wr;
   } exp_t;

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  num;
      logic [15:0] dig;
      int          tot;
   } adj_vec_t;

   exp_t     sb_q[$];
   adj_vec_t tbl[8];
   int       n_chk  = 0;
   int       n_pass = 0;
   int       wrap_cnt = 0;
   int       run_rises = 0;
   logic     run_prev = 1'b0;

   // Event counters sampled on the falling edge
   always @(negedge clk) begin
      if (wrap) wrap_cnt = wrap_cnt + 1;
      if (running && !run_prev) run_rises = run_rises + 1;
      run_prev = running;
   end

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Push expectation, then pop and compare against the outputs at the next falling edge
   task automatic check(string nm, logic [15:0] d, int t, logic r, logic [3:0] m, logic w);
      exp_t e;
      e.nm = nm; e.dig = d; e.tot = t; e.run = r; e.mask = m; e.wr = w;
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      cmp({e.nm, " digits"}, 32'(digits), 32'(e.dig));
      cmp({e.nm, " total"}, 32'(total_seconds), 32'(e.tot));
      cmp({e.nm, " running"}, 32'(running), 32'(e.run));
      cmp({e.nm, " blink_mask"}, 32'(blink_mask), 32'(e.mask));
      cmp({e.nm, " wrap"}, 32'(wrap), 32'(e.wr));
      @(posedge clk);
      #1;
   endtask

   task automatic press_sp();
      btn_set_pause = 1'b1;
      step(3);
      btn_set_pause = 1'b0;
      step(2);
   endtask

   task automatic press_rst();
      btn_reset = 1'b1;
      step(3);
      btn_reset = 1'b0;
      step(2);
   endtask

   task automatic pulse_1hz();
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      step(1);
   endtask

   task automatic pulse_adj();
      tick_adj = 1'b1;
      step(1);
      tick_adj = 1'b0;
      step(1);
   endtask

   int snap;

   initial begin
      // Adjust loads applied in order from 00:00; rejected loads leave the count unchanged
      tbl[0] = '{2'd0, 4'd3,  16'h0003, 3};
      tbl[1] = '{2'd1, 4'd7,  16'h0003, 3};
      tbl[2] = '{2'd1, 4'd4,  16'h0043, 43};
      tbl[3] = '{2'd2, 4'd10, 16'h0043, 43};
      tbl[4] = '{2'd2, 4'd8,  16'h0843, 523};
      tbl[5] = '{2'd3, 4'd6,  16'h6843, 4123};
      tbl[6] = '{2'd0, 4'd15, 16'h6843, 4123};
      tbl[7] = '{2'd1, 4'd5,  16'h6853, 4133};

      step(3);
      check("in_reset", 16'h0000, 0, 1'b0, 4'd0, 1'b0);
      rst = 1'b1;
      step(2);
      check("after_reset", 16'h0000, 0, 1'b0, 4'd0, 1'b0);
      pulse_1hz();
      check("tick_paused_idle", 16'h0000, 0, 1'b0, 4'd0, 1'b0);

      // Run for 75 seconds
      press_sp();
      check("start_run", 16'h0000, 0, 1'b1, 4'd0, 1'b0);
      for (int i = 0; i < 75; i++) pulse_1hz();
      check("run_75", 16'h0115, 75, 1'b1, 4'd0, 1'b0);

      // Reset press coincident with tick and set/pause press
      btn_reset = 1'b1;
      btn_set_pause = 1'b1;
      step(1);
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      step(2);
      btn_reset = 1'b0;
      btn_set_pause = 1'b0;
      step(2);
      check("reset_wins", 16'h0000, 0, 1'b0, 4'd0, 1'b0);

      // Pause holds the count
      press_sp();
      for (int i = 0; i < 3; i++) pulse_1hz();
      press_sp();
      check("paused_3", 16'h0003, 3, 1'b0, 4'd0, 1'b0);
      pulse_1hz();
      check("tick_in_pause", 16'h0003, 3, 1'b0, 4'd0, 1'b0);

      // Long hold counts as one press
      snap = run_rises;
      btn_set_pause = 1'b1;
      step(1000);
      check("held_1000", 16'h0003, 3, 1'b1, 4'd0, 1'b0);
      btn_set_pause = 1'b0;
      step(2);
      cmp("held_single_edge", 32'(run_rises - snap), 32'd1);
      press_sp();

      // Adjust mode: clear, then table of loads
      adj = 1'b1;
      step(2);
      press_rst();
      check("adj_reset", 16'h0000, 0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         sel = tbl[i].sel;
         num = tbl[i].num;
         press_sp();
         check($sformatf("adj_vec%0d", i), tbl[i].dig, tbl[i].tot, 1'b0, 4'd0, 1'b0);
      end

      // Blink on minute-ones digit
      sel = 2'd2;
      step(1);
      for (int k = 0; k < 6; k++) begin
         pulse_adj();
         check($sformatf("blink%0d", k), 16'h6853, 4133, 1'b0,
               (k % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
      end
      pulse_adj();
      sel = 2'd3;
      step(1);
      check("blink_sel_move", 16'h6853, 4133, 1'b0, 4'b1000, 1'b0);
      adj = 1'b0;
      step(1);
      check("adj_exit", 16'h6853, 4133, 1'b0, 4'd0, 1'b0);
      pulse_1hz();
      check("exit_is_pause", 16'h6853, 4133, 1'b0, 4'd0, 1'b0);

      // Preset 99:59 and roll over
      adj = 1'b1;
      step(2);
      sel = 2'd0; num = 4'd9; press_sp();
      sel = 2'd1; num = 4'd5; press_sp();
      sel = 2'd2; num = 4'd9; press_sp();
      sel = 2'd3; num = 4'd9; press_sp();
      check("preset_max", 16'h9959, 5999, 1'b0, 4'd0, 1'b0);
      adj = 1'b0;
      step(2);
      press_sp();
      check("run_at_max", 16'h9959, 5999, 1'b1, 4'd0, 1'b0);
      snap = wrap_cnt;
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
      check("saturate", 16'h9959, 5999, 1'b0, 4'd0, 1'b1);
      check("saturate_after", 16'h9959, 5999, 1'b0, 4'd0, 1'b0);
      step(3);
      cmp("wrap_one_cycle", 32'(wrap_cnt - snap), 32'd1);
      pulse_1hz();
      check("saturate_hold", 16'h9959, 5999, 1'b0, 4'd0, 1'b0);
`else
      check("wrap", 16'h0000, 0, 1'b1, 4'd0, 1'b1);
      check("wrap_after", 16'h0000, 0, 1'b1, 4'd0, 1'b0);
      step(3);
      cmp("wrap_one_cycle", 32'(wrap_cnt - snap), 32'd1);
      pulse_1hz();
      check("post_wrap_tick", 16'h0001, 1, 1'b1, 4'd0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
